// File: rtl/block_collider_if.sv
// Erase/bounce bus between the collision engine (master) and the renderer / ball logic (slave).
// Also carries the raster counters and ball position the engine samples.
interface block_collider_if;
   logic [9:0] hor_count;
   logic [9:0] ver_count;
   logic [9:0] ball_x;
   logic [9:0] ball_y;
   logic       erase_enable;
   logic [5:0] erase_pos;
   logic       bounce_x;
   logic       bounce_y;
   logic [4:0] hit_count;
   logic       all_cleared;

   modport master (
      input  hor_count, ver_count, ball_x, ball_y,
      output erase_enable, erase_pos, bounce_x, bounce_y, hit_count, all_cleared
   );

   modport slave (
      output hor_count, ver_count, ball_x, ball_y,
      input  erase_enable, erase_pos, bounce_x, bounce_y, hit_count, all_cleared
   );
endinterface

// File: rtl/block_collider.sv
// Once-per-frame ball/brick collision scan issuing at most one erase + bounce pulse.
// Optional score counter (hit_count/all_cleared) built only when COLLIDER_SCORE_EN is defined.
module block_collider #(
   parameter int NUM_BLOCKS   = 12,
   parameter int BALL_SIZE    = 7,
   parameter int BLOCK_WIDTH  = 80,
   parameter int BLOCK_HEIGHT = 30
) (
   input  logic              CLK_25MH,
   input  logic              reset,
   block_collider_if.master  bus
);

   typedef enum logic [1:0] {IDLE, LATCH, SCAN, HIT} state_t;

   localparam logic [10:0] BALL_W  = 11'(BALL_SIZE);
   localparam logic [10:0] BLK_W   = 11'(BLOCK_WIDTH);
   localparam logic [10:0] BLK_H   = 11'(BLOCK_HEIGHT);
   localparam logic [10:0] HALF_B  = 11'(BALL_SIZE / 2);
   localparam logic [3:0]  LAST_K  = 4'(NUM_BLOCKS - 1);

   // Geometry must stay identical to what the renderer draws.
   function automatic logic [10:0] brick_x(input logic [3:0] idx);
      case (idx)
         4'd0, 4'd5:         brick_x = 11'd40;
         4'd1, 4'd6, 4'd10:  brick_x = 11'd160;
         4'd2, 4'd7:         brick_x = 11'd280;
         4'd3, 4'd8, 4'd11:  brick_x = 11'd400;
         4'd4, 4'd9:         brick_x = 11'd520;
         default:            brick_x = 11'd0;
      endcase
   endfunction

   function automatic logic [10:0] brick_y(input logic [3:0] idx);
      case (idx)
         4'd0, 4'd1, 4'd2, 4'd3, 4'd4: brick_y = 11'd40;
         4'd5, 4'd6, 4'd7, 4'd8, 4'd9: brick_y = 11'd90;
         4'd10, 4'd11:                 brick_y = 11'd140;
         default:                      brick_y = 11'd0;
      endcase
   endfunction

   state_t                  state_q, state_d;
   logic [9:0]              bx_q, bx_d;
   logic [9:0]              by_q, by_d;
   logic [3:0]              k_q, k_d;
   logic [NUM_BLOCKS-1:0]   active_q, active_d;
   logic                    erase_enable_q, erase_enable_d;
   logic [5:0]              erase_pos_q, erase_pos_d;
   logic                    bounce_x_q, bounce_x_d;
   logic                    bounce_y_q, bounce_y_d;

   logic [10:0] cur_x, cur_y, bx_ext, by_ext, cx;
   logic        trigger, overlap, center_in;

   always_comb begin
      cur_x     = brick_x(k_q);
      cur_y     = brick_y(k_q);
      bx_ext    = {1'b0, bx_q};
      by_ext    = {1'b0, by_q};
      cx        = bx_ext + HALF_B;
      trigger   = (bus.hor_count == 10'd0) && (bus.ver_count == 10'd480);
      overlap   = active_q[k_q]
                  && (bx_ext <= cur_x + BLK_W) && (bx_ext + BALL_W >= cur_x)
                  && (by_ext <= cur_y + BLK_H) && (by_ext + BALL_W >= cur_y);
      center_in = (cx >= cur_x) && (cx <= cur_x + BLK_W);
   end

   always_comb begin
      state_d        = state_q;
      bx_d           = bx_q;
      by_d           = by_q;
      k_d            = k_q;
      active_d       = active_q;
      erase_enable_d = 1'b0;
      erase_pos_d    = erase_pos_q;
      bounce_x_d     = 1'b0;
      bounce_y_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (trigger) state_d = LATCH;
         end
         LATCH: begin
            bx_d    = bus.ball_x;
            by_d    = bus.ball_y;
            k_d     = 4'd0;
            state_d = SCAN;
         end
         SCAN: begin
            if (overlap)              state_d = HIT;
            else if (k_q == LAST_K)   state_d = IDLE;
            else                      k_d = k_q + 4'd1;
         end
         HIT: begin
            erase_enable_d   = 1'b1;
            erase_pos_d      = {2'b00, k_q};
            bounce_y_d       = center_in;
            bounce_x_d       = !center_in;
            active_d[k_q]    = 1'b0;
            state_d          = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK_25MH) begin
      if (!reset) begin
         state_q        <= IDLE;
         bx_q           <= '0;
         by_q           <= '0;
         k_q            <= '0;
         active_q       <= '1;
         erase_enable_q <= 1'b0;
         erase_pos_q    <= '0;
         bounce_x_q     <= 1'b0;
         bounce_y_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         bx_q           <= bx_d;
         by_q           <= by_d;
         k_q            <= k_d;
         active_q       <= active_d;
         erase_enable_q <= erase_enable_d;
         erase_pos_q    <= erase_pos_d;
         bounce_x_q     <= bounce_x_d;
         bounce_y_q     <= bounce_y_d;
      end
   end

   assign bus.erase_enable = erase_enable_q;
   assign bus.erase_pos    = erase_pos_q;
   assign bus.bounce_x     = bounce_x_q;
   assign bus.bounce_y     = bounce_y_q;

`ifdef COLLIDER_SCORE_EN
   logic [4:0] hit_count_q, hit_count_d;

   // Saturation is a safety net; the 12-bit mask already caps real hits.
   always_comb begin
      hit_count_d = hit_count_q;
      if (state_q == HIT && hit_count_q < 5'(NUM_BLOCKS))
         hit_count_d = hit_count_q + 5'd1;
   end

   always_ff @(posedge CLK_25MH) begin
      if (!reset) hit_count_q <= '0;
      else        hit_count_q <= hit_count_d;
   end

   assign bus.hit_count   = hit_count_q;
   assign bus.all_cleared = (hit_count_q == 5'(NUM_BLOCKS));
`else
   assign bus.hit_count   = '0;
   assign bus.all_cleared = 1'b0;
`endif

endmodule

// File: doc/block_collider.md
# block_collider

Ball-versus-brick collision engine for the Breakout datapath. Once per frame, at the start of vertical blanking, it latches the ball position and scans a private copy of the 12-brick active mask, using the same brick geometry the VGA renderer draws. On the first overlapping brick it drives a one-cycle `erase_enable`/`erase_pos` pulse into the renderer's erase port, along with a bounce-axis pulse for the ball-motion logic. It is the producer of the erase interface that the renderer consumes.

## Interface
- `NUM_BLOCKS`, 12: bricks tracked; indices 0..11.
- `BALL_SIZE`, 7: ball box spans `[ball_x, ball_x+BALL_SIZE]` × `[ball_y, ball_y+BALL_SIZE]`, inclusive.
- `BLOCK_WIDTH`, 80: brick box spans `[x, x+BLOCK_WIDTH]`, inclusive.
- `BLOCK_HEIGHT`, 30: brick box spans `[y, y+BLOCK_HEIGHT]`, inclusive.
- `CLK_25MH` input 1: pixel clock; all logic on the rising edge.
- `reset` input 1: synchronous, active-low (0 = reset).
- `hor_count` input 10: renderer horizontal counter, 0..799.
- `ver_count` input 10: renderer vertical counter, 0..524.
- `ball_x` input 10: ball top-left x.
- `ball_y` input 10: ball top-left y.
- `erase_enable` output 1: one-cycle erase strobe.
- `erase_pos` output 6: brick index being erased; valid while `erase_enable`=1.
- `bounce_x` output 1: one-cycle pulse, coincident with `erase_enable`; reverse the ball's x direction.
- `bounce_y` output 1: one-cycle pulse, coincident with `erase_enable`; reverse the ball's y direction.
- `hit_count` output 5: number of bricks erased since reset.
- `all_cleared` output 1: high when `hit_count` = `NUM_BLOCKS`.

## Operation
- **Brick geometry** (fixed, matches the renderer):
  - Bricks 0-4: x = 40 + 120·i, y = 40.
  - Bricks 5-9: x = 40 + 120·(i−5), y = 90.
  - Brick 10: x = 160, y = 140.
  - Brick 11: x = 400, y = 140.
- **Active mask:** 12 bits, all ones after reset. A bit is cleared in the same cycle its erase pulse is issued.
- **States:** IDLE, LATCH, SCAN, HIT.
  - IDLE → LATCH when `hor_count`=0 and `ver_count`=480 (frame trigger). The trigger is ignored in every other state.
  - LATCH: register `ball_x`/`ball_y` into `bx`/`by`; set `k`=0; go to SCAN.
  - SCAN: evaluate brick `k` in one cycle. Hit = `active[k]` && `bx <= x+80` && `bx+7 >= x` && `by <= y+30` && `by+7 >= y`.
    - Hit → HIT, with `erase_pos` = `k`.
    - No hit and `k`=11 → IDLE.
    - Otherwise `k`+1.
  - HIT: assert `erase_enable` plus exactly one of `bounce_x`/`bounce_y`; clear `active[k]`; increment `hit_count`; go to IDLE.
- **Bounce axis:** ball center `cx = bx+3`.
  - If `x <= cx <= x+80`, pulse `bounce_y`.
  - Otherwise pulse `bounce_x`.
- **Arithmetic:** all additions are done at 11 bits so `ball_x+7` near 1023 cannot wrap.
- **Erase limit:** at most one erase per frame. When several bricks overlap, the lowest index wins; the rest are caught in later frames.
- **Saturation:** `hit_count` saturates at 12. Once `all_cleared`=1, scans still run but can never hit.
- **Reset asserted in any state:** next state IDLE; mask all ones; all outputs 0 on the following edge. Any in-flight pulse is dropped.

## Timing
- **Reset values:** `erase_enable`=0, `erase_pos`=0, `bounce_x`=0, `bounce_y`=0, `hit_count`=0, `all_cleared`=0.
- **Trigger:** sampled at edge T.
  - LATCH occupies cycle T+1.
  - Brick `k` is evaluated at edge T+2+k.
- **Hit latency:** on a hit at brick `k`, `erase_enable`, the bounce pulse and `erase_pos`=k are high for exactly the one cycle following edge T+3+k. All three are registered outputs.
- **No-hit case:** back in IDLE by edge T+14.
- **Frame budget:** the scan completes well inside blanking (45 lines), so the renderer's mask and this block's mask agree before active video resumes.
- **Outputs between pulses:** `erase_pos` holds its last value and is don't-care while `erase_enable`=0. `hit_count` and `all_cleared` update on the edge that ends the HIT cycle.

## Configuration
- `COLLIDER_SCORE_EN` defined:
  - `hit_count` counter and `all_cleared` flag are implemented as described.
- `COLLIDER_SCORE_EN` undefined:
  - No counter logic is built.
  - `hit_count` is tied to 0 and `all_cleared` to 0.
  - Ports remain present; collision and erase behaviour is unchanged.

## Test plan
- Ball (60,65), trigger → `erase_pos`=0, `erase_enable` high exactly 1 cycle at T+3, `bounce_y`=1, `hit_count`=1.
- Ball (36,50) → brick 0 hit with `cx`=39 outside 40..120 → `bounce_x`=1, `bounce_y`=0.
- Ball (300,300) → no pulses; FSM returns to IDLE by T+14. Ball (60,65) held for two frames → erase on frame 1 only.
- Position the ball over each brick in turn over 12 frames → `erase_pos` 0..11 in order, `hit_count`=12, `all_cleared`=1. A 13th frame gives no pulse.
- `reset`=0 asserted during SCAN at `k`=5 with brick 7 pending → no pulse; outputs 0. After release, a ball on brick 0 erases brick 0 again (mask restored).
- Build without `COLLIDER_SCORE_EN`, run the 12-hit sequence → erase pulses identical; `hit_count`=0 and `all_cleared`=0 throughout.
